// File: rtl/dbus_xbar_pkg.sv
// Shared bus widths, decode constants and FSM encoding for the data-bus crossbar.
package dbus_xbar_pkg;

   localparam int XLEN        = 32;
   localparam int BUS_WIDTH   = 32;
   localparam int BUS_ACC_CNT = 4;
   localparam int BUS_ACC_W   = $clog2(BUS_ACC_CNT);
   localparam int DBUS_SPAN_W = 6;
   localparam int DBUS_IDX_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } dbus_state_e;

   // Low-order offset mask of a window of 2**span bytes.
   function automatic logic [XLEN-1:0] span_mask(input logic [DBUS_SPAN_W-1:0] span);
      return (XLEN'(1) << span) - XLEN'(1);
   endfunction

endpackage

// File: rtl/dbus_xbar_decode.sv
// Address window decoder: one-hot winning slot plus hit flag, lowest index wins.
module dbus_decode
   import dbus_xbar_pkg::*;
#(
   parameter int                               SLAVE_CNT = 6,
   parameter logic [SLAVE_CNT*XLEN-1:0]        S_BASE    = '0,
   parameter logic [SLAVE_CNT*DBUS_SPAN_W-1:0] S_SPAN    = '0
) (
   input  logic [XLEN-1:0]      addr_i,
   output logic [SLAVE_CNT-1:0] onehot_o,
   output logic                 hit_o
);

   logic [XLEN-1:0] mask;

   // Scan from slot 0 upward; the first matching window locks out the rest.
   always_comb begin
      onehot_o = '0;
      hit_o    = 1'b0;
      mask     = '0;
      for (int i = 0; i < SLAVE_CNT; i++) begin
         mask = span_mask(S_SPAN[i*DBUS_SPAN_W +: DBUS_SPAN_W]);
         if (!hit_o && ((addr_i & ~mask) == S_BASE[i*XLEN +: XLEN])) begin
            onehot_o[i] = 1'b1;
            hit_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dbus_xbar.sv
// Single-master data-bus interconnect: window decode, one outstanding
// transaction, locally generated decode-miss and timeout error responses.
module dbus_xbar
   import dbus_xbar_pkg::*;
#(
   parameter int                               SLAVE_CNT   = 6,
   parameter logic [SLAVE_CNT*XLEN-1:0]        S_BASE      = {32'h80000000, 32'h40000000,
                                                              32'h30000000, 32'h20000000,
                                                              32'h10000000, 32'h00000000},
   parameter logic [SLAVE_CNT*DBUS_SPAN_W-1:0] S_SPAN      = {6'd31, 6'd3, 6'd24,
                                                              6'd19, 6'd12, 6'd12},
   parameter int                               TIMEOUT_CYC = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           m_req_i,
   input  logic [XLEN-1:0]                m_addr_i,
   input  logic                           m_w_rb_i,
   input  logic [BUS_ACC_W-1:0]           m_acc_i,
   input  logic [BUS_WIDTH-1:0]           m_wdata_i,
   output logic                           m_ready_o,
   output logic                           m_resp_o,
   output logic [BUS_WIDTH-1:0]           m_rdata_o,
   output logic                           m_fault_o,
   output logic [SLAVE_CNT-1:0]           s_req_o,
   output logic [SLAVE_CNT*XLEN-1:0]      s_addr_o,
   output logic [SLAVE_CNT-1:0]           s_w_rb_o,
   output logic [SLAVE_CNT*BUS_ACC_W-1:0] s_acc_o,
   output logic [SLAVE_CNT*BUS_WIDTH-1:0] s_wdata_o,
   input  logic [SLAVE_CNT-1:0]           s_resp_i,
   input  logic [SLAVE_CNT*BUS_WIDTH-1:0] s_rdata_i,
   input  logic [SLAVE_CNT-1:0]           s_fault_i,
   output logic                           bus_fault_o,
   output logic                           timeout_o,
   output logic [DBUS_IDX_W-1:0]          err_idx_o
);

   localparam int              CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   dbus_state_e             state_q;
   logic [DBUS_IDX_W-1:0]   sel_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [DBUS_IDX_W-1:0]   err_idx_q;

   logic [SLAVE_CNT-1:0]    win_onehot;
   logic                    hit;
   logic [DBUS_IDX_W-1:0]   win_idx;
   logic [DBUS_IDX_W-1:0]   cur_idx;
   logic                    cur_resp;
   logic                    cur_fault;
   logic [BUS_WIDTH-1:0]    cur_rdata;
   logic                    accept;

   dbus_decode #(
      .SLAVE_CNT (SLAVE_CNT),
      .S_BASE    (S_BASE),
      .S_SPAN    (S_SPAN)
   ) u_decode (
      .addr_i   (m_addr_i),
      .onehot_o (win_onehot),
      .hit_o    (hit)
   );

   // One-hot winner to slot index.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < SLAVE_CNT; i++) begin
         if (win_onehot[i]) win_idx = DBUS_IDX_W'(i);
      end
   end

   // In IDLE the candidate is the decode winner (same-cycle response); otherwise the latched slot.
   always_comb begin
      cur_idx   = (state_q == ST_IDLE) ? win_idx : sel_q;
      cur_resp  = 1'b0;
      cur_fault = 1'b0;
      cur_rdata = '0;
      for (int i = 0; i < SLAVE_CNT; i++) begin
         if (cur_idx == DBUS_IDX_W'(i)) begin
            cur_resp  = s_resp_i[i];
            cur_fault = s_fault_i[i];
            cur_rdata = s_rdata_i[i*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   assign m_ready_o = (state_q == ST_IDLE);
   assign accept    = m_req_i & m_ready_o;
   assign s_req_o   = (accept && hit) ? win_onehot : '0;
   assign s_w_rb_o  = {SLAVE_CNT{m_w_rb_i}};
   assign err_idx_o = err_idx_q;

   // Per-slot offsets; access size and write data are broadcast.
   always_comb begin
      s_addr_o  = '0;
      s_acc_o   = '0;
      s_wdata_o = '0;
      for (int i = 0; i < SLAVE_CNT; i++) begin
         s_addr_o[i*XLEN +: XLEN]           = m_addr_i & span_mask(S_SPAN[i*DBUS_SPAN_W +: DBUS_SPAN_W]);
         s_acc_o[i*BUS_ACC_W +: BUS_ACC_W]  = m_acc_i;
         s_wdata_o[i*BUS_WIDTH +: BUS_WIDTH] = m_wdata_i;
      end
   end

   // Master-side response, decode-miss and timeout pulses; a real response beats a timeout.
   always_comb begin
      m_resp_o    = 1'b0;
      m_fault_o   = 1'b0;
      m_rdata_o   = '0;
      bus_fault_o = 1'b0;
      timeout_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!hit) begin
                  bus_fault_o = 1'b1;
               end else if (cur_resp) begin
                  m_resp_o  = 1'b1;
                  m_fault_o = cur_fault;
                  m_rdata_o = cur_rdata;
               end
            end
         end
         ST_BUSY: begin
            if (cur_resp) begin
               m_resp_o  = 1'b1;
               m_fault_o = cur_fault;
               m_rdata_o = cur_rdata;
            end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
               m_resp_o  = 1'b1;
               m_fault_o = 1'b1;
               timeout_o = 1'b1;
            end
         end
         ST_ERR: begin
            m_resp_o  = 1'b1;
            m_fault_o = 1'b1;
         end
         default: ;
      endcase
   end

   // Transaction FSM: slot latch, BUSY cycle counter and sticky error index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         err_idx_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (hit) begin
                     sel_q <= win_idx;
                     cnt_q <= '0;
                     if (cur_resp) begin
                        if (cur_fault) err_idx_q <= win_idx;
                     end else begin
                        state_q <= ST_BUSY;
                     end
                  end else begin
                     state_q <= ST_ERR;
                  end
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cur_resp) begin
                  state_q <= ST_IDLE;
                  if (cur_fault) err_idx_q <= sel_q;
               end else if (timeout_o) begin
                  state_q   <= ST_IDLE;
                  err_idx_q <= sel_q;
               end
            end
            ST_ERR:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_xbar.sv
// Directed bench for dbus_xbar with the default six-slot map and an 8-cycle timeout.
module tb_dbus_xbar;
   import dbus_xbar_pkg::*;

   localparam int N = 6;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    m_req;
   logic [XLEN-1:0]         m_addr;
   logic                    m_w_rb;
   logic [BUS_ACC_W-1:0]    m_acc;
   logic [BUS_WIDTH-1:0]    m_wdata;
   logic                    m_ready;
   logic                    m_resp;
   logic [BUS_WIDTH-1:0]    m_rdata;
   logic                    m_fault;
   logic [N-1:0]            s_req;
   logic [N*XLEN-1:0]       s_addr;
   logic [N-1:0]            s_w_rb;
   logic [N*BUS_ACC_W-1:0]  s_acc;
   logic [N*BUS_WIDTH-1:0]  s_wdata;
   logic [N-1:0]            s_resp;
   logic [N*BUS_WIDTH-1:0]  s_rdata;
   logic [N-1:0]            s_fault;
   logic                    bus_fault;
   logic                    timeout;
   logic [3:0]              err_idx;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   dbus_xbar #(.TIMEOUT_CYC(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req_i     (m_req),
      .m_addr_i    (m_addr),
      .m_w_rb_i    (m_w_rb),
      .m_acc_i     (m_acc),
      .m_wdata_i   (m_wdata),
      .m_ready_o   (m_ready),
      .m_resp_o    (m_resp),
      .m_rdata_o   (m_rdata),
      .m_fault_o   (m_fault),
      .s_req_o     (s_req),
      .s_addr_o    (s_addr),
      .s_w_rb_o    (s_w_rb),
      .s_acc_o     (s_acc),
      .s_wdata_o   (s_wdata),
      .s_resp_i    (s_resp),
      .s_rdata_i   (s_rdata),
      .s_fault_i   (s_fault),
      .bus_fault_o (bus_fault),
      .timeout_o   (timeout),
      .err_idx_o   (err_idx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m_req   = 1'b0;
      m_addr  = '0;
      m_w_rb  = 1'b0;
      m_acc   = '0;
      m_wdata = '0;
      s_resp  = '0;
      s_rdata = '0;
      s_fault = '0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      #3;
      check("rst_m_ready", m_ready, 1);
      check("rst_m_resp", m_resp, 0);
      check("rst_s_req", s_req, 0);
      check("rst_err_idx", err_idx, 0);
      check("rst_flags", {bus_fault, timeout, m_fault}, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Read 0x20000104 from sram, response three cycles later.
      m_req = 1'b1; m_addr = 32'h20000104; m_acc = 2'd2;
      #3;
      check("sram_s_req", s_req, 6'b000100);
      check("sram_s_addr", s_addr[2*XLEN +: XLEN], 32'h00000104);
      check("sram_s_acc", s_acc[5*BUS_ACC_W +: BUS_ACC_W], 2'd2);
      check("sram_no_resp", m_resp, 0);
      tick();
      m_req = 1'b0;
      #3;
      check("sram_busy1_ready", m_ready, 0);
      check("sram_busy1_resp", m_resp, 0);
      tick();
      m_req = 1'b1; m_addr = 32'h10000000;
      #3;
      check("dropped_req_s_req", s_req, 0);
      check("sram_busy2_ready", m_ready, 0);
      tick();
      m_req = 1'b0;
      s_resp[2] = 1'b1; s_rdata[2*BUS_WIDTH +: BUS_WIDTH] = 32'hDEADBEEF;
      #3;
      check("sram_resp", m_resp, 1);
      check("sram_rdata", m_rdata, 32'hDEADBEEF);
      check("sram_fault", m_fault, 0);
      check("sram_busy3_ready", m_ready, 0);
      tick();
      idle_inputs();
      #3;
      check("sram_back_idle", m_ready, 1);
      check("sram_rdata_zero", m_rdata, 0);

      // Write 0x10000010 to tcm with same-cycle response.
      m_req = 1'b1; m_addr = 32'h10000010; m_w_rb = 1'b1; m_wdata = 32'hCAFEF00D;
      s_resp[1] = 1'b1; s_rdata[1*BUS_WIDTH +: BUS_WIDTH] = 32'h0000ABCD;
      #3;
      check("tcm_s_req", s_req, 6'b000010);
      check("tcm_s_addr", s_addr[1*XLEN +: XLEN], 32'h00000010);
      check("tcm_w_rb", s_w_rb, 6'b111111);
      check("tcm_wdata_bcast", s_wdata[4*BUS_WIDTH +: BUS_WIDTH], 32'hCAFEF00D);
      check("tcm_resp", m_resp, 1);
      check("tcm_ready", m_ready, 1);
      tick();
      idle_inputs();
      #3;
      check("tcm_stay_idle", m_ready, 1);
      check("tcm_resp_done", m_resp, 0);

      // Decode miss at 0x50000000.
      m_req = 1'b1; m_addr = 32'h50000000;
      #3;
      check("miss_bus_fault", bus_fault, 1);
      check("miss_s_req", s_req, 0);
      check("miss_no_resp", m_resp, 0);
      tick();
      m_req = 1'b0;
      #3;
      check("err_resp", {m_resp, m_fault}, 2'b11);
      check("err_rdata", m_rdata, 0);
      check("err_ready", m_ready, 0);
      check("err_bus_fault_pulse", bus_fault, 0);
      tick();
      #3;
      check("err_back_idle", {m_ready, m_resp}, 2'b10);

      // Timeout on silent nor slot 3.
      m_req = 1'b1; m_addr = 32'h30000000;
      #3;
      check("nor_s_req", s_req, 6'b001000);
      for (int k = 1; k <= 7; k++) begin
         tick();
         m_req = 1'b0;
         #3;
         check("nor_wait_no_resp", {m_resp, timeout}, 2'b00);
      end
      tick();
      #3;
      check("nor_timeout", timeout, 1);
      check("nor_to_resp", {m_resp, m_fault}, 2'b11);
      check("nor_to_rdata", m_rdata, 0);
      tick();
      #3;
      check("nor_err_idx", err_idx, 3);
      check("nor_ready", m_ready, 1);
      s_resp[3] = 1'b1; s_rdata[3*BUS_WIDTH +: BUS_WIDTH] = 32'h33333333;
      #1;
      check("late_resp_ignored", m_resp, 0);
      check("late_rdata_zero", m_rdata, 0);
      tick();
      idle_inputs();

      // Bridge read with a spurious response on slot 0 and a faulting reply.
      m_req = 1'b1; m_addr = 32'h80001000;
      #3;
      check("bridge_s_req", s_req, 6'b100000);
      check("bridge_s_addr", s_addr[5*XLEN +: XLEN], 32'h00001000);
      tick();
      m_req = 1'b0;
      s_resp[0] = 1'b1; s_rdata[0 +: BUS_WIDTH] = 32'h11111111;
      #3;
      check("spurious_no_resp", m_resp, 0);
      check("spurious_rdata", m_rdata, 0);
      tick();
      s_resp = '0;
      s_resp[5] = 1'b1; s_fault[5] = 1'b1; s_rdata[5*BUS_WIDTH +: BUS_WIDTH] = 32'h22222222;
      #3;
      check("bridge_resp", {m_resp, m_fault}, 2'b11);
      check("bridge_rdata", m_rdata, 32'h22222222);
      tick();
      idle_inputs();
      #3;
      check("bridge_err_idx", err_idx, 5);

      // Reset while BUSY, then a stale response from the old slave.
      m_req = 1'b1; m_addr = 32'h20000000;
      tick();
      m_req = 1'b0;
      #3;
      check("pre_rst_busy", m_ready, 0);
      rst = 1'b1;
      #1;
      check("rst_async_ready", m_ready, 1);
      check("rst_async_err_idx", err_idx, 0);
      tick();
      rst = 1'b0;
      s_resp[2] = 1'b1; s_rdata[2*BUS_WIDTH +: BUS_WIDTH] = 32'h44444444;
      #3;
      check("post_rst_no_resp", m_resp, 0);
      check("post_rst_rdata", m_rdata, 0);
      check("post_rst_flags", {bus_fault, timeout, m_fault}, 0);
      check("post_rst_s_req", s_req, 0);
      check("post_rst_ready", m_ready, 1);
      tick();
      idle_inputs();
      #3;
      check("post_rst_idle", {m_ready, m_resp}, 2'b10);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/dbus_xbar.md
Name: dbus_xbar

Overview:
- Parametrised single-master data-bus interconnect: decodes the master address against SLAVE_CNT base/span windows and routes the request to one slave.
- Tracks the one outstanding transaction and returns the response from the selected slave only.
- Generates error responses itself for decode misses and slave timeouts.
- Sits between the core data port and the memory/peripheral slaves (rom, tcm, sram, nor, qspinor, bridge).

Parameters:
- SLAVE_CNT, 6: number of slave ports, 1..16.
- S_BASE, {32'h80000000,32'h40000000,32'h30000000,32'h20000000,32'h10000000,32'h00000000}: flattened bases, slot i at [i*XLEN +: XLEN].
- S_SPAN, {6'd31,6'd3,6'd24,6'd19,6'd12,6'd12}: flattened log2 window sizes, slot i at [i*6 +: 6], each 1..XLEN-1.
- TIMEOUT_CYC, 255: cycles in BUSY before timeout abort; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m_req  in  1  request pulse, one cycle
- m_addr  in  XLEN  byte address
- m_w_rb  in  1  1=write, 0=read
- m_acc  in  clog2(BUS_ACC_CNT)  access size
- m_wdata  in  BUS_WIDTH  write data
- m_ready  out  1  master may issue m_req this cycle
- m_resp  out  1  response pulse
- m_rdata  out  BUS_WIDTH  read data, valid with m_resp
- m_fault  out  1  error response, valid with m_resp
- s_req  out  SLAVE_CNT  per-slave request
- s_addr  out  SLAVE_CNT*XLEN  per-slave offset (m_addr masked to span)
- s_w_rb  out  SLAVE_CNT  per-slave write flag
- s_acc  out  SLAVE_CNT*clog2(BUS_ACC_CNT)  per-slave access size
- s_wdata  out  SLAVE_CNT*BUS_WIDTH  per-slave write data
- s_resp  in  SLAVE_CNT  per-slave response
- s_rdata  in  SLAVE_CNT*BUS_WIDTH  per-slave read data
- s_fault  in  SLAVE_CNT  per-slave fault
- bus_fault  out  1  decode-miss pulse
- timeout  out  1  timeout-abort pulse
- err_idx  out  4  index of last slave that faulted or timed out

Behaviour:
- Decode:
  - hit_i = (m_addr & ~((1<<span_i)-1)) == base_i.
  - Overlapping windows: lowest index wins.
  - s_addr slot i = m_addr & ((1<<span_i)-1).
  - s_w_rb, s_acc and s_wdata are broadcast to all slots.
- s_req[i] = m_req & m_ready & winner==i. This is combinational, so there is zero added request latency.
- FSM states: IDLE, BUSY, ERR. Reset state is IDLE.
- Reset values:
  - all outputs 0, except m_ready=1;
  - sel_q=0, cnt=0, err_idx=0.
- IDLE, on m_req with a hit:
  - forward to winner; sel_q<=winner; cnt<=0.
  - If s_resp[winner] is high in the same cycle, pass the response through and stay IDLE.
  - Otherwise go to BUSY.
- IDLE, on m_req with a miss:
  - bus_fault=1 that cycle; no s_req.
  - Go to ERR.
- ERR (one cycle): m_resp=1, m_fault=1, m_rdata=0. Then return to IDLE.
- BUSY:
  - m_ready=0; cnt increments.
  - On s_resp[sel_q]: m_resp=1, m_rdata=s_rdata[sel_q], m_fault=s_fault[sel_q]; go to IDLE.
  - If TIMEOUT_CYC!=0 and cnt==TIMEOUT_CYC-1 with no s_resp[sel_q]: m_resp=1, m_fault=1, m_rdata=0, timeout=1, err_idx<=sel_q; go to IDLE.
  - If s_resp arrives in the same cycle the timeout would fire, the response wins and no timeout is raised.
- m_ready=1 only in IDLE.
- m_req while m_ready=0 is a master protocol error: it is dropped, no s_req is issued, and no response is generated.
- Slave responses:
  - s_resp from any slave other than sel_q, or any s_resp while not BUSY (unless same-cycle IDLE), is ignored. This covers late responses after a timeout.
  - m_rdata is 0 whenever m_resp=0.
- err_idx updates on timeout and on any forwarded response with fault=1. It holds otherwise.
- Reset mid-transaction returns to IDLE immediately. Any later slave response is ignored.

Decomposition:
- Shared header femto.vh supplies XLEN, BUS_WIDTH and BUS_ACC_CNT.
- Add DBUS_SPAN_W=6 and the FSM state encodings to femto.vh.
- One sub-module, dbus_decode: purely combinational address to one-hot winner plus hit flag, with priority encoding. It is instantiated once.

Test Plan:
- Read 0x20000104, sram (slot 2) responds after 3 cycles with 0xDEADBEEF -> s_req[2] pulses with s_addr=0x104; m_resp 3 cycles later with 0xDEADBEEF, m_fault=0; m_ready low for those 3 cycles.
- Write 0x10000010, tcm (slot 1) asserts s_resp in the same cycle -> s_req[1]=1 and m_resp=1 in that cycle; FSM stays IDLE; m_ready never drops.
- Read 0x50000000 (no window) -> bus_fault=1 in the request cycle; next cycle m_resp=1, m_fault=1, m_rdata=0; no s_req.
- TIMEOUT_CYC=8, read 0x30000000, nor (slot 3) silent -> after 8 BUSY cycles m_resp=1, m_fault=1, timeout=1, err_idx=3. A later s_resp[3] produces no m_resp.
- Read to bridge (slot 5) while slot 0 pulses a spurious s_resp with 0x11111111; bridge returns 0x22222222 with fault=1 -> m_rdata=0x22222222, m_fault=1, err_idx=5.
- Assert rst while BUSY, then s_resp on the old slave -> no m_resp; m_ready=1; all outputs at reset values.
